// File: rtl/key_frame_filter.sv
// Frame-rate key debouncer: snapshots raw key flags on each frame strobe, scans one
// key per cycle against per-key disagreement counters, then commits the result.
module key_frame_filter #(
    parameter int NUM_KEYS   = 17,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 2,
    parameter int CNT_W      = 4
) (
    input  logic                clock_54mhz,
    input  logic                reset_b,
    input  logic                frame_done,
    input  logic [NUM_KEYS-1:0] raw_keys,
    output logic [NUM_KEYS-1:0] key_num,
    output logic                note_ready,
    output logic                busy,
    output logic                overrun
);

    // state  | meaning
    // IDLE   | waiting for frame_done; snapshot raw_keys when it arrives
    // SCAN   | evaluate one key per cycle, idx 0..NUM_KEYS-1, into next_keys
    // COMMIT | publish next_keys to key_num, pulse note_ready on change

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W:0]   ON_THR   = (CNT_W+1)'(ON_FRAMES);
    localparam logic [CNT_W:0]   OFF_THR  = (CNT_W+1)'(OFF_FRAMES);
    localparam logic [CNT_W:0]   ONE_EXT  = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_KEYS-1:0] snap;
    logic [NUM_KEYS-1:0] next_keys;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    logic             cur_raw;
    logic             cur_stable;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W:0]   cur_thr;
    logic             cur_flip;

    // Compare one bit wider than the counter so cnt+1 never wraps before the threshold test.
    always_comb begin
        cur_raw    = snap[idx];
        cur_stable = next_keys[idx];
        cur_cnt    = cnt[idx];
        cur_thr    = cur_stable ? OFF_THR : ON_THR;
        cur_flip   = (cur_raw != cur_stable) && (({1'b0, cur_cnt} + ONE_EXT) >= cur_thr);
    end

    always_ff @(posedge clock_54mhz or negedge reset_b) begin
        if (!reset_b) begin
            state      <= IDLE;
            snap       <= '0;
            next_keys  <= '0;
            idx        <= '0;
            key_num    <= '0;
            note_ready <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            note_ready <= 1'b0;
            if (frame_done && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_done) begin
                        snap      <= raw_keys;
                        next_keys <= key_num;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_raw == cur_stable) begin
                        cnt[idx] <= '0;
                    end else if (cur_flip) begin
                        next_keys[idx] <= ~cur_stable;
                        cnt[idx]       <= '0;
                    end else begin
                        cnt[idx] <= cur_cnt + CNT_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    key_num    <= next_keys;
                    note_ready <= (next_keys != key_num);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
